lif_neuron_layer: RTL and testbench

//  Array of leaky integrate-and-fire neurons sitting directly downstream of the lateral-inhibition stage.

---
 rtl/snn_pkg.sv | 26 ++
 rtl/lif_neuron.sv | 77 +++++++
 rtl/lif_neuron_layer.sv | 51 +++++
 tb/tb_lif_neuron_layer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types, limits and the saturation helper for the spiking-neuron datapath.
package snn_pkg;

    localparam int unsigned NO_OF_NEURONS = 10;
    localparam int unsigned CURRENT_W     = 20;
    localparam int unsigned SUM_W         = 22;

    typedef logic signed [CURRENT_W-1:0] current_t;
    typedef logic signed [SUM_W-1:0]     sum_t;
    typedef current_t current_arr_t[NO_OF_NEURONS];

    localparam current_t CURRENT_MAX = current_t'(20'h7FFFF);
    localparam current_t CURRENT_MIN = current_t'(20'h80000);

    // Saturate a widened sum back into the 20-bit current range.
    function automatic current_t sat20(input sum_t x);
        if (x > sum_t'(CURRENT_MAX)) begin
            return CURRENT_MAX;
        end
        if (x < sum_t'(CURRENT_MIN)) begin
            return CURRENT_MIN;
        end
        return current_t'(x);
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, refractory counter and
// registered spike pulse, all advancing only on the time-step strobe.
module lif_neuron
    import snn_pkg::*;
#(
    parameter current_t    THRESHOLD  = 20'sd1000,
    parameter current_t    V_RESET    = 20'sd0,
    parameter current_t    V_MIN      = -20'sd1000,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int unsigned REFRACTORY = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     step,
    input  current_t in_current,
    output logic     spike,
    output current_t membrane
);

    // A zero-length refractory still needs a 1-bit counter that simply stays 0.
    localparam int unsigned REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    current_t         v_q, v_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic             spike_q, spike_d;

    sum_t     leak_c;
    sum_t     sum_c;
    current_t clamped_c;

    // Leak, integrate in 22 bits, then clamp to [V_MIN, CURRENT_MAX].
    always_comb begin
        leak_c = '0;
        if (LEAK_SHIFT != 0) begin
            leak_c = sum_t'(v_q >>> LEAK_SHIFT);
        end
        sum_c     = sum_t'(v_q) - leak_c + sum_t'(in_current);
        clamped_c = sat20(sum_c);
        if (clamped_c < V_MIN) begin
            clamped_c = V_MIN;
        end
    end

    always_comb begin
        v_d     = v_q;
        ref_d   = ref_q;
        spike_d = 1'b0;
        if (step) begin
            if (ref_q != '0) begin
                ref_d = ref_q - REF_W'(1);
                v_d   = V_RESET;
            end else if (clamped_c >= THRESHOLD) begin
                spike_d = 1'b1;
                v_d     = V_RESET;
                ref_d   = REF_W'(REFRACTORY);
            end else begin
                v_d = clamped_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= V_RESET;
            ref_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            ref_q   <= ref_d;
            spike_q <= spike_d;
        end
    end

    assign spike    = spike_q;
    assign membrane = v_q;

endmodule

// File: rtl/lif_neuron_layer.sv
// Layer of independent LIF neurons behind lateral inhibition; spikes and their
// valid strobe appear one cycle after the time-step that produced them.
module lif_neuron_layer
    import snn_pkg::*;
#(
    parameter int unsigned NO_OF_NEURONS = snn_pkg::NO_OF_NEURONS,
    parameter current_t    THRESHOLD     = 20'sd1000,
    parameter current_t    V_RESET       = 20'sd0,
    parameter current_t    V_MIN         = -20'sd1000,
    parameter int unsigned LEAK_SHIFT    = 4,
    parameter int unsigned REFRACTORY    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  current_t                 in_current [NO_OF_NEURONS],
    output logic [NO_OF_NEURONS-1:0] out_spikes,
    output logic                     spike_valid,
    output current_t                 membrane   [NO_OF_NEURONS]
);

    logic spike_valid_q;

    for (genvar i = 0; i < NO_OF_NEURONS; i++) begin : g_neuron
        lif_neuron #(
            .THRESHOLD  (THRESHOLD),
            .V_RESET    (V_RESET),
            .V_MIN      (V_MIN),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRACTORY (REFRACTORY)
        ) u_neuron (
            .clk        (clk),
            .reset      (reset),
            .step       (step),
            .in_current (in_current[i]),
            .spike      (out_spikes[i]),
            .membrane   (membrane[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_valid_q <= 1'b0;
        end else begin
            spike_valid_q <= step;
        end
    end

    assign spike_valid = spike_valid_q;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Bench for lif_neuron_layer: a default-parameter layer and a no-leak/no-refractory
// layer share stimulus; a behavioural model feeds per-cycle expectations to a scoreboard.
module tb_lif_neuron_layer;
    import snn_pkg::*;

    localparam int N = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        step  = 1'b0;
    current_t    in_cur [N];
    logic [N-1:0] spk_a, spk_b;
    logic        val_a, val_b;
    current_t    mem_a [N];
    current_t    mem_b [N];

    lif_neuron_layer #(.NO_OF_NEURONS(N)) dut_a (
        .clk(clk), .reset(reset), .step(step), .in_current(in_cur),
        .out_spikes(spk_a), .spike_valid(val_a), .membrane(mem_a)
    );

    lif_neuron_layer #(.NO_OF_NEURONS(N), .LEAK_SHIFT(0), .REFRACTORY(0)) dut_b (
        .clk(clk), .reset(reset), .step(step), .in_current(in_cur),
        .out_spikes(spk_b), .spike_valid(val_b), .membrane(mem_b)
    );

    typedef struct {
        logic         valid;
        logic [N-1:0] spk;
        int           mem [N];
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   va[N], ra[N], vb[N], rb[N];
    int   checks   = 0;
    int   failures = 0;

    function automatic void neuron_next(input int v, input int r, input int cur,
                                        input int ls, input int refr,
                                        output int vn, output int rn, output logic s);
        int sum;
        s  = 1'b0;
        vn = v;
        rn = r;
        if (r > 0) begin
            rn = r - 1;
            vn = 0;
        end else begin
            sum = v + cur;
            if (ls > 0) sum = sum - (v >>> ls);
            if (sum > 524287) sum = 524287;
            if (sum < -1000)  sum = -1000;
            if (sum >= 1000) begin
                s  = 1'b1;
                vn = 0;
                rn = refr;
            end else begin
                vn = sum;
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue what both layers must show after the edge.
    task automatic drive(input logic st, input logic rs, input int cur[N]);
        exp_t ea, eb;
        logic s;
        @(negedge clk);
        step  = st;
        reset = rs;
        for (int i = 0; i < N; i++) in_cur[i] = 20'(cur[i]);
        ea.valid = st && !rs;
        eb.valid = st && !rs;
        ea.spk   = '0;
        eb.spk   = '0;
        for (int i = 0; i < N; i++) begin
            if (rs) begin
                va[i] = 0; ra[i] = 0; vb[i] = 0; rb[i] = 0;
            end else if (st) begin
                neuron_next(va[i], ra[i], cur[i], 4, 2, va[i], ra[i], s);
                ea.spk[i] = s;
                neuron_next(vb[i], rb[i], cur[i], 0, 0, vb[i], rb[i], s);
                eb.spk[i] = s;
            end
            ea.mem[i] = va[i];
            eb.mem[i] = vb[i];
        end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic drive0(input logic st, input logic rs, input int c0);
        int c[N];
        for (int i = 0; i < N; i++) c[i] = 0;
        c[0] = c0;
        drive(st, rs, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: compare every registered output one step after each queued cycle.
    exp_t ma, mb;
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            ma = qa.pop_front();
            mb = qb.pop_front();
            checks += 4;
            if (val_a !== ma.valid) begin
                failures++;
                $display("FAIL sb_valid_a got=%b exp=%b t=%0t", val_a, ma.valid, $time);
            end
            if (spk_a !== ma.spk) begin
                failures++;
                $display("FAIL sb_spikes_a got=%b exp=%b t=%0t", spk_a, ma.spk, $time);
            end
            if (val_b !== mb.valid || spk_b !== mb.spk) begin
                failures++;
                $display("FAIL sb_spk_b got=%b/%b exp=%b/%b t=%0t", val_b, spk_b, mb.valid, mb.spk, $time);
            end
            for (int i = 0; i < N; i++) begin
                if (int'(mem_a[i]) != ma.mem[i] || int'(mem_b[i]) != mb.mem[i]) begin
                    failures++;
                    $display("FAIL sb_membrane n=%0d got=%0d/%0d exp=%0d/%0d t=%0t",
                             i, mem_a[i], mem_b[i], ma.mem[i], mb.mem[i], $time);
                    break;
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) drive0(1'b1, 1'b1, 300);
        settle();
        checks++;
        if (spk_a !== '0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got spk=%b valid=%b exp 0/0", spk_a, val_a);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_a[i] !== 20'sd0 || mem_b[i] !== 20'sd0) begin
                failures++;
                $display("FAIL reset_membrane n=%0d got=%0d/%0d exp=0", i, mem_a[i], mem_b[i]);
            end
        end
    endtask

    task automatic test_integrate();
        int exp_v[3] = '{300, 582, 846};
        for (int k = 0; k < 3; k++) begin
            drive0(1'b1, 1'b0, 300);
            settle();
            checks++;
            if (int'(mem_a[0]) != exp_v[k] || spk_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL integrate_step%0d got=%0d spk=%b exp=%0d spk=0", k + 1, mem_a[0], spk_a[0], exp_v[k]);
            end
        end
        drive0(1'b1, 1'b0, 300);
        settle();
        checks++;
        if (spk_a[0] !== 1'b1 || mem_a[0] !== 20'sd0 || val_a !== 1'b1) begin
            failures++;
            $display("FAIL fire_step4 got spk=%b mem=%0d valid=%b exp 1/0/1", spk_a[0], mem_a[0], val_a);
        end
        drive0(1'b0, 1'b0, 300);
        settle();
        checks++;
        if (spk_a !== '0 || val_a !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width got spk=%b valid=%b exp 0/0", spk_a, val_a);
        end
    endtask

    task automatic test_refractory();
        for (int k = 0; k < 2; k++) begin
            drive0(1'b1, 1'b0, 300);
            settle();
            checks++;
            if (mem_a[0] !== 20'sd0 || spk_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL refractory_step%0d got mem=%0d spk=%b exp 0/0", k + 5, mem_a[0], spk_a[0]);
            end
        end
        drive0(1'b1, 1'b0, 300);
        settle();
        checks++;
        if (int'(mem_a[0]) != 300) begin
            failures++;
            $display("FAIL post_refractory got=%0d exp=300", mem_a[0]);
        end
    endtask

    task automatic test_clamp();
        drive0(1'b1, 1'b0, -524288);
        settle();
        checks++;
        if (int'(mem_a[0]) != -1000 || int'(mem_b[0]) != -1000) begin
            failures++;
            $display("FAIL clamp_floor got=%0d/%0d exp=-1000", mem_a[0], mem_b[0]);
        end
        repeat (3) drive0(1'b1, 1'b0, 0);
        settle();
        checks++;
        if (int'(mem_b[0]) != -1000) begin
            failures++;
            $display("FAIL clamp_hold_noleak got=%0d exp=-1000", mem_b[0]);
        end
    endtask

    task automatic test_equality();
        drive0(1'b0, 1'b1, 0);
        drive0(1'b1, 1'b0, 1000);
        settle();
        checks++;
        if (spk_a[0] !== 1'b1 || spk_b[0] !== 1'b1) begin
            failures++;
            $display("FAIL equal_threshold got=%b/%b exp=1/1", spk_a[0], spk_b[0]);
        end
        for (int k = 0; k < 3; k++) begin
            drive0(1'b1, 1'b0, 1000);
            settle();
            checks++;
            if (spk_b[0] !== 1'b1 || mem_b[0] !== 20'sd0) begin
                failures++;
                $display("FAIL no_refractory_b%0d got spk=%b mem=%0d exp 1/0", k, spk_b[0], mem_b[0]);
            end
        end
    endtask

    task automatic test_reset_mid_refractory();
        drive0(1'b0, 1'b1, 0);
        drive0(1'b1, 1'b0, 1000);
        drive0(1'b1, 1'b1, 1000);
        settle();
        checks++;
        if (spk_a !== '0 || val_a !== 1'b0 || mem_a[0] !== 20'sd0) begin
            failures++;
            $display("FAIL reset_wins got spk=%b valid=%b mem=%0d exp 0/0/0", spk_a, val_a, mem_a[0]);
        end
        drive0(1'b1, 1'b0, 1000);
        settle();
        checks++;
        if (spk_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL fire_after_reset got=%b exp=1", spk_a[0]);
        end
    endtask

    task automatic test_multi();
        int c[N];
        for (int i = 0; i < N; i++) c[i] = (i % 2 == 0) ? 1000 : 100 * i;
        drive0(1'b0, 1'b1, 0);
        drive(1'b1, 1'b0, c);
        settle();
        checks++;
        if (spk_a !== 10'b0101010101) begin
            failures++;
            $display("FAIL multi_fire got=%b exp=0101010101", spk_a);
        end
        repeat (4) drive(1'b1, 1'b0, c);
        drive(1'b0, 1'b0, c);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_cur[i] = '0;
            va[i] = 0; ra[i] = 0; vb[i] = 0; rb[i] = 0;
        end
        test_reset();
        test_integrate();
        test_refractory();
        test_clamp();
        test_equality();
        test_reset_mid_refractory();
        test_multi();
        settle();
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", qa.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
